// File: rtl/wb_bank_reader_if.sv
// Bus bundle for wb_bank_reader: command, bank port and element stream.
// master = the reader, slave = the environment (bank, downstream, controller).
interface wb_bank_reader_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 128,
    parameter int ELEM_WIDTH = 32
);
    // command / status
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic                  busy;
    logic                  done;
    // bank read port
    logic [ADDR_WIDTH-1:0] bank_A;
    logic                  bank_EN;
    logic                  bank_REN;
    logic                  bank_WEN;
    logic [DATA_WIDTH-1:0] bank_Q;
    // element stream
    logic [ELEM_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        input  start, base_addr, word_cnt, bank_Q, out_ready,
        output busy, done, bank_A, bank_EN, bank_REN, bank_WEN,
               out_data, out_valid, out_last
    );

    modport slave (
        output start, base_addr, word_cnt, bank_Q, out_ready,
        input  busy, done, bank_A, bank_EN, bank_REN, bank_WEN,
               out_data, out_valid, out_last
    );
endinterface

// File: rtl/wb_bank_reader.sv
// Witness bank read sequencer: reads a contiguous run of bank words, keeps up
// to two words in flight (buffered + pending), and unpacks each word into
// ELEM_WIDTH elements on a valid/ready stream, lane 0 (LSBs) first.
module wb_bank_reader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 128,
    parameter int ELEM_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_bank_reader_if.master bus
);
    localparam int EPW    = DATA_WIDTH / ELEM_WIDTH;
    localparam int LANE_W = (EPW > 1) ? $clog2(EPW) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(EPW - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;             // next address to issue
    logic [ADDR_WIDTH:0]     issue_left_q, issue_left_d; // words not yet issued
    logic [ADDR_WIDTH:0]     pop_left_q, pop_left_d;     // words not yet fully streamed
    logic                    pending_q, pending_d;       // read issued last cycle
    logic [DATA_WIDTH-1:0]   buf_q [2];
    logic [DATA_WIDTH-1:0]   buf_d [2];
    logic                    head_q, head_d;
    logic [1:0]              occ_q, occ_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic                    done_q, done_d;

    logic                    issue;
    logic                    xfer;
    logic                    pop;
    logic                    last_elem;
    logic                    valid;
    logic [EPW-1:0][ELEM_WIDTH-1:0] head_word;

    // Read issue credit, lane select and stream handshake decode
    always_comb begin
        head_word = buf_q[head_q];
        valid     = (occ_q != 2'd0);
        // occupancy + in-flight read must leave room for the returning word
        issue     = (state_q == RUN) && (issue_left_q != '0) &&
                    ((occ_q + {1'b0, pending_q}) < 2'd2);
        last_elem = (pop_left_q == (ADDR_WIDTH+1)'(1)) && (lane_q == LAST_LANE);
        xfer      = valid && bus.out_ready;
        pop       = xfer && (lane_q == LAST_LANE);
    end

    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? head_word[lane_q] : '0;
    assign bus.out_last  = valid && last_elem;
    assign bus.bank_EN   = issue;
    assign bus.bank_REN  = issue;
    assign bus.bank_WEN  = 1'b0;
    assign bus.bank_A    = issue ? addr_q : '0;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;

    // Next-state: command accept, address/credit counters, buffer and lane
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        pending_d    = issue;
        buf_d        = buf_q;
        head_d       = head_q;
        occ_d        = occ_q;
        lane_d       = lane_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.word_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = RUN;
                        addr_d       = bus.base_addr;
                        issue_left_d = bus.word_cnt;
                        pop_left_d   = bus.word_cnt;
                        head_d       = 1'b0;
                        occ_d        = 2'd0;
                        lane_d       = '0;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d       = addr_q + 1'b1;   // wraps at bank depth
                    issue_left_d = issue_left_q - 1'b1;
                end
                // credit rule guarantees occ <= 1 here, so tail = head ^ occ[0]
                if (pending_q)
                    buf_d[head_q ^ occ_q[0]] = bus.bank_Q;
                if (xfer)
                    lane_d = pop ? '0 : lane_q + 1'b1;
                if (pop) begin
                    head_d     = ~head_q;
                    pop_left_d = pop_left_q - 1'b1;
                end
                occ_d = occ_q + {1'b0, pending_q} - {1'b0, pop};
                if (xfer && last_elem) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any run without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            pending_q    <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            head_q       <= 1'b0;
            occ_q        <= 2'd0;
            lane_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            pending_q    <= pending_d;
            buf_q        <= buf_d;
            head_q       <= head_d;
            occ_q        <= occ_d;
            lane_q       <= lane_d;
            done_q       <= done_d;
        end
    end
endmodule

// File: tb/tb_wb_bank_reader.sv
// Bench for wb_bank_reader: bank model, stream monitor and a list-based
// reference (expected reads = base+i mod depth, elements = lanes of each word).
module tb_wb_bank_reader;
    localparam int AW    = 13;
    localparam int DW    = 128;
    localparam int EW    = 32;
    localparam int EPW   = DW / EW;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_bank_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ELEM_WIDTH(EW)) bus ();

    wb_bank_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ELEM_WIDTH(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // bank: registered read, Q holds when not reading
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk)
        if (bus.bank_EN && !bus.bank_WEN) bus.bank_Q <= mem[bus.bank_A];

    // monitor, sampled on the falling edge
    int            cyc = 0, done_cnt = 0, done_cyc = 0, stall_viol = 0, ctl_viol = 0;
    logic          done_busy = 1'b0;
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_data = '0;
    logic [EW-1:0] elem_q [$];
    logic          last_q [$];
    int            xcyc_q [$];
    int            rd_q [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data))
            stall_viol <= stall_viol + 1;
        prev_stall <= bus.out_valid && !bus.out_ready;
        prev_data  <= bus.out_data;
        if (bus.bank_REN !== bus.bank_EN || bus.bank_WEN !== 1'b0)
            ctl_viol <= ctl_viol + 1;
        if (bus.bank_EN) rd_q.push_back(int'(bus.bank_A));
        if (bus.out_valid && bus.out_ready) begin
            elem_q.push_back(bus.out_data);
            last_q.push_back(bus.out_last);
            xcyc_q.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_busy <= bus.busy;
        end
    end

    int n_assert = 0, n_fail = 0;
    int ready_pct = 100;
    int e0, r0, d0;
    logic [EW-1:0] exp_e [$];
    int            exp_a [$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.out_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    // builds the reference, pulses start, checks first-element latency
    task automatic issue_cmd(input int base, input int cnt);
        int a;
        e0 = elem_q.size(); r0 = rd_q.size(); d0 = done_cnt;
        exp_e.delete(); exp_a.delete();
        for (int w = 0; w < cnt; w++) begin
            a = (base + w) % DEPTH;
            exp_a.push_back(a);
            for (int l = 0; l < EPW; l++) exp_e.push_back(mem[a][l*EW +: EW]);
        end
        tick();
        bus.start = 1'b1; bus.base_addr = AW'(base); bus.word_cnt = (AW+1)'(cnt);
        tick();
        bus.start = 1'b0;
        if (cnt == 0) begin
            check("zl_done", DW'(bus.done), 1);
            check("zl_busy", DW'(bus.busy), 0);
        end else begin
            check("busy_after_start", DW'(bus.busy), 1);
            check("lat_valid_t0", DW'(bus.out_valid), 0);
            tick();
            check("lat_valid_t1", DW'(bus.out_valid), 0);
            tick();
            check("lat_valid_t2", DW'(bus.out_valid), 1);
        end
    endtask

    // waits for done and compares elements, last flags, reads and timing
    task automatic finish_cmd(input bit gapless);
        int n, ne, lastx;
        n = 0;
        while (done_cnt == d0 && n < 4000) begin tick(); n++; end
        check("done_count", DW'(done_cnt - d0), 1);
        check("done_pulse_drop", DW'(bus.done), 0);
        check("busy_idle", DW'(bus.busy), 0);
        ne = elem_q.size() - e0;
        check("n_elem", DW'(ne), DW'(exp_e.size()));
        for (int i = 0; i < exp_e.size(); i++)
            if (e0 + i < elem_q.size()) begin
                check($sformatf("elem%0d", i), DW'(elem_q[e0+i]), DW'(exp_e[i]));
                check($sformatf("last%0d", i), DW'(last_q[e0+i]), DW'(i == exp_e.size() - 1));
            end
        check("n_reads", DW'(rd_q.size() - r0), DW'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++)
            if (r0 + i < rd_q.size())
                check($sformatf("rd_addr%0d", i), DW'(rd_q[r0+i]), DW'(exp_a[i]));
        if (ne > 0) begin
            lastx = xcyc_q[e0+ne-1];
            check("done_after_last", DW'(done_cyc), DW'(lastx + 1));
            check("busy_in_done", DW'(done_busy), 0);
            if (gapless) check("no_gaps", DW'(lastx - xcyc_q[e0]), DW'(ne - 1));
        end
    endtask

    initial begin
        int ne, rd, dn, n;
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.word_cnt = '0; bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[5] = 128'h44443333_22221111_00000000_FFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", DW'(bus.busy), 0);
        check("rst_done", DW'(bus.done), 0);
        check("rst_en", DW'(bus.bank_EN), 0);
        check("rst_ren", DW'(bus.bank_REN), 0);
        check("rst_a", DW'(bus.bank_A), 0);
        check("rst_valid", DW'(bus.out_valid), 0);
        check("rst_last", DW'(bus.out_last), 0);
        check("rst_data", DW'(bus.out_data), 0);
        rst = 1'b0;

        // single word, known vector
        ready_pct = 100;
        issue_cmd(5, 1);
        finish_cmd(1'b1);
        check("vec_lane0", DW'(exp_e[0]), 128'hFFFFFFFF);
        check("vec_lane3", DW'(exp_e[3]), 128'h44443333);

        // streaming
        issue_cmd(0, 16);
        finish_cmd(1'b1);

        // backpressure, same data as a ready=1 run
        ready_pct = 30;
        issue_cmd(0, 8);
        finish_cmd(1'b0);
        check("stall_stable", DW'(stall_viol), 0);

        // address wrap
        ready_pct = 100;
        issue_cmd(8190, 4);
        finish_cmd(1'b1);

        // zero-length command
        issue_cmd(77, 0);
        finish_cmd(1'b0);

        // start while busy is ignored
        issue_cmd(100, 4);
        tick();
        bus.start = 1'b1; bus.base_addr = AW'(200); bus.word_cnt = (AW+1)'(7);
        tick();
        bus.start = 1'b0;
        finish_cmd(1'b1);
        ne = elem_q.size(); rd = rd_q.size(); dn = done_cnt;
        repeat (20) tick();
        check("ignored_elems", DW'(elem_q.size() - ne), 0);
        check("ignored_reads", DW'(rd_q.size() - rd), 0);
        check("ignored_done", DW'(done_cnt - dn), 0);

        // random commands under random backpressure
        for (int k = 0; k < 6; k++) begin
            ready_pct = int'($urandom_range(20, 100));
            issue_cmd(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(1, 6)));
            finish_cmd(1'b0);
        end
        check("stall_stable_rand", DW'(stall_viol), 0);

        // reset mid-run after 5 transfers
        ready_pct = 100;
        issue_cmd(300, 8);
        n = 0;
        while (elem_q.size() - e0 < 5 && n < 200) begin tick(); n++; end
        check("mid_xfers", DW'(elem_q.size() - e0 >= 5), 1);
        dn = done_cnt;
        rst = 1'b1;
        #1;
        check("mrst_busy", DW'(bus.busy), 0);
        check("mrst_en", DW'(bus.bank_EN), 0);
        check("mrst_a", DW'(bus.bank_A), 0);
        check("mrst_valid", DW'(bus.out_valid), 0);
        check("mrst_last", DW'(bus.out_last), 0);
        check("mrst_data", DW'(bus.out_data), 0);
        repeat (3) tick();
        check("mrst_no_done", DW'(done_cnt - dn), 0);
        rst = 1'b0;
        issue_cmd(400, 2);
        finish_cmd(1'b1);

        check("bank_ctl", DW'(ctl_viol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
